// File: rtl/spi_slave_responder_pkg.sv
// Shared types and constants for the fabric-side SPI responder and the
// frame parsers that sit behind it.
package spi_resp_pkg;

    localparam int BYTE_W = 8;

    // First two bytes of every frame the bridge sends to a fabric responder.
    localparam logic [15:0] FRAME_HEADER = 16'h59A6;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    function automatic logic is_frame_header(input logic [15:0] word);
        return (word == FRAME_HEADER);
    endfunction

endpackage

// File: rtl/spi_slave_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line, followed by a
// one-flop history register that yields single-cycle rise/fall strobes.
module spi_sync_edge
    import spi_resp_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] stage_r;
    logic              prev_r;
    logic              sync_s;

    assign sync_s = stage_r[STAGES-1];

    // Synchronizer chain plus previous-value flop for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_r <= {STAGES{RESET_VAL}};
            prev_r  <= RESET_VAL;
        end else begin
            stage_r <= {stage_r[STAGES-2:0], din};
            prev_r  <= sync_s;
        end
    end

    assign rise = sync_s & ~prev_r;
    assign fall = ~sync_s & prev_r;

endmodule

// File: rtl/spi_slave_responder.sv
// Mode-0 SPI slave running on the system clock: oversampled inputs, received
// bytes as one-cycle strobes, reply bytes through a one-deep holding register.
module spi_slave_responder
    import spi_resp_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_FILL   = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              SPI_SCK,
    input  logic              SPI_CS,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              SPI_MISO_OE,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              selected,
    output logic              underrun
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic sck_rise_s;
    logic sck_fall_s;
    logic cs_rise_s;
    logic cs_fall_s;
    logic mosi_s;

    logic [SYNC_N-1:0] mosi_sync_r;

    spi_state_t        state_r;
    logic [2:0]        bit_cnt_r;
    logic [BYTE_W-2:0] rx_shift_r;
    // miso_r is bit 7 of the TX shifter; tx_rest_r holds bits 6..0.
    logic [BYTE_W-2:0] tx_rest_r;
    logic              byte_done_r;
    logic              miso_r;
    logic              miso_oe_r;
    logic [BYTE_W-1:0] rx_data_r;
    logic              rx_valid_r;
    logic              underrun_r;
    logic              selected_r;

    logic [BYTE_W-1:0] hold_r;
    logic              tx_ready_r;

    logic              accept_s;
    logic              load_s;
    logic [BYTE_W-1:0] next_byte_s;

    spi_sync_edge #(
        .STAGES   (SYNC_N),
        .RESET_VAL(1'b0)
    ) u_sck_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (SPI_SCK),
        .rise   (sck_rise_s),
        .fall   (sck_fall_s)
    );

    // CS idles high, so its chain resets high to avoid a spurious select.
    spi_sync_edge #(
        .STAGES   (SYNC_N),
        .RESET_VAL(1'b1)
    ) u_cs_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (SPI_CS),
        .rise   (cs_rise_s),
        .fall   (cs_fall_s)
    );

    // MOSI synchronizer, same depth as SCK so data lines up with its edges.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mosi_sync_r <= {SYNC_N{1'b0}};
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_N-2:0], SPI_MOSI};
        end
    end

    assign mosi_s = mosi_sync_r[SYNC_N-1];

    // Byte source for the TX shifter and whether it is consumed this cycle.
    always_comb begin
        next_byte_s = IDLE_FILL;
        load_s      = 1'b0;
        if (!tx_ready_r) begin
            next_byte_s = hold_r;
        end else begin
            next_byte_s = IDLE_FILL;
        end
        case (state_r)
            IDLE:    load_s = cs_fall_s;
            ACTIVE:  load_s = ~cs_rise_s & sck_fall_s & byte_done_r;
            default: load_s = 1'b0;
        endcase
    end

    assign accept_s = tx_valid & tx_ready_r;

    // Reply holding register: a new handshake wins over a same-cycle drain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_r     <= 8'h00;
            tx_ready_r <= 1'b1;
        end else if (accept_s) begin
            hold_r     <= tx_data;
            tx_ready_r <= 1'b0;
        end else if (load_s && !tx_ready_r) begin
            tx_ready_r <= 1'b1;
        end else begin
            tx_ready_r <= tx_ready_r;
        end
    end

    // Transfer FSM: selection, bit counting, RX assembly and TX shifting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 3'd0;
            rx_shift_r  <= 7'd0;
            tx_rest_r   <= 7'd0;
            byte_done_r <= 1'b0;
            miso_r      <= 1'b1;
            miso_oe_r   <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            underrun_r  <= 1'b0;
            selected_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            underrun_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_r     <= ACTIVE;
                        selected_r  <= 1'b1;
                        bit_cnt_r   <= 3'd0;
                        rx_shift_r  <= 7'd0;
                        byte_done_r <= 1'b0;
                        miso_oe_r   <= 1'b1;
                        miso_r      <= next_byte_s[BYTE_W-1];
                        tx_rest_r   <= next_byte_s[BYTE_W-2:0];
                        underrun_r  <= tx_ready_r;
                    end
                end
                ACTIVE: begin
                    // CS release takes priority over any SCK edge seen with it.
                    if (cs_rise_s) begin
                        state_r     <= IDLE;
                        selected_r  <= 1'b0;
                        bit_cnt_r   <= 3'd0;
                        rx_shift_r  <= 7'd0;
                        tx_rest_r   <= 7'd0;
                        byte_done_r <= 1'b0;
                        miso_oe_r   <= 1'b0;
                        miso_r      <= 1'b1;
                    end else if (sck_rise_s) begin
                        rx_shift_r <= {rx_shift_r[BYTE_W-3:0], mosi_s};
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            rx_data_r   <= {rx_shift_r, mosi_s};
                            rx_valid_r  <= 1'b1;
                            byte_done_r <= 1'b1;
                        end
                    end else if (sck_fall_s) begin
                        if (byte_done_r) begin
                            miso_r      <= next_byte_s[BYTE_W-1];
                            tx_rest_r   <= next_byte_s[BYTE_W-2:0];
                            underrun_r  <= tx_ready_r;
                            byte_done_r <= 1'b0;
                        end else begin
                            miso_r    <= tx_rest_r[BYTE_W-2];
                            tx_rest_r <= {tx_rest_r[BYTE_W-3:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    selected_r <= 1'b0;
                    miso_oe_r  <= 1'b0;
                    miso_r     <= 1'b1;
                end
            endcase
        end
    end

    assign SPI_MISO    = miso_r;
    assign SPI_MISO_OE = miso_oe_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign tx_ready    = tx_ready_r;
    assign selected    = selected_r;
    assign underrun    = underrun_r;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Scoreboard bench for spi_slave_responder: directed SPI frames push expected
// RX bytes and MISO bits; independent monitors pop and compare.
module tb_spi_slave_responder;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       SPI_SCK  = 1'b0;
    logic       SPI_CS   = 1'b1;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_MISO;
    logic       SPI_MISO_OE;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       selected;
    logic       underrun;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_exp_q[$];
    logic       miso_exp_q[$];

    int   underrun_cnt = 0;
    int   rdy_rise_cnt = 0;
    int   rdy_fall_cnt = 0;
    logic rdy_prev     = 1'b1;

    int ur0;
    int r0;
    int f0;

    spi_slave_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .SPI_SCK    (SPI_SCK),
        .SPI_CS     (SPI_CS),
        .SPI_MOSI   (SPI_MOSI),
        .SPI_MISO   (SPI_MISO),
        .SPI_MISO_OE(SPI_MISO_OE),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .selected   (selected),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_miso(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) miso_exp_q.push_back(b[7-i]);
    endtask

    // One SCK period at clk/8: 4 clk low with MOSI set up, 4 clk high.
    task automatic spi_bit(input logic b, input logic release_cs);
        SPI_MOSI = b;
        wait_clk(4);
        SPI_SCK = 1'b1;
        wait_clk(4);
        SPI_SCK = 1'b0;
        if (release_cs) SPI_CS = 1'b1;
    endtask

    task automatic spi_send(input logic [31:0] w, input int nbits, input logic release_cs);
        for (int i = 0; i < nbits; i++) spi_bit(w[31-i], release_cs && (i == nbits - 1));
    endtask

    task automatic spi_frame(input logic [31:0] w, input int nbits);
        SPI_CS = 1'b0;
        spi_send(w, nbits, 1'b1);
        wait_clk(8);
    endtask

    task automatic offer(input logic [7:0] b);
        bit done;
        done = 1'b0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 4000 && !done; i++) begin
            if (tx_ready) done = 1'b1;
            else @(negedge clk);
        end
        if (done) begin
            @(posedge clk);
            #1;
        end else begin
            n_checks++;
            $display("FAIL offer_timeout: byte %02h never accepted", b);
        end
        tx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_miso"}, SPI_MISO, 1'b1);
        chk({tag, "_miso_oe"}, SPI_MISO_OE, 1'b0);
        chk({tag, "_rx_data"}, rx_data, 8'h00);
        chk({tag, "_rx_valid"}, rx_valid, 1'b0);
        chk({tag, "_tx_ready"}, tx_ready, 1'b1);
        chk({tag, "_selected"}, selected, 1'b0);
        chk({tag, "_underrun"}, underrun, 1'b0);
    endtask

    task automatic end_frame(input string tag, input int exp_ur, input int ur_base);
        chk({tag, "_rx_pending"}, rx_exp_q.size(), 32'd0);
        chk({tag, "_miso_pending"}, miso_exp_q.size(), 32'd0);
        chk({tag, "_underruns"}, underrun_cnt - ur_base, exp_ur);
        chk({tag, "_oe_idle"}, SPI_MISO_OE, 1'b0);
        chk({tag, "_miso_idle"}, SPI_MISO, 1'b1);
        chk({tag, "_selected"}, selected, 1'b0);
        rx_exp_q.delete();
        miso_exp_q.delete();
    endtask

    // RX / underrun / tx_ready monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rx_extra: got %02h expected no strobe", rx_data);
            end else begin
                chk("rx_data", rx_data, rx_exp_q.pop_front());
            end
        end
        if (underrun) underrun_cnt++;
        if (tx_ready && !rdy_prev) rdy_rise_cnt++;
        if (!tx_ready && rdy_prev) rdy_fall_cnt++;
        rdy_prev = tx_ready;
    end

    // MISO monitor: the master samples on every SCK rise.
    always @(posedge SPI_SCK) begin
        chk("miso_oe_on_sck", SPI_MISO_OE, 1'b1);
        if (miso_exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL miso_extra: got %0b expected no SCK edge", SPI_MISO);
        end else begin
            chk("miso_bit", SPI_MISO, miso_exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        wait_clk(4);
        check_reset_vals("reset");
        reset_n = 1'b1;
        wait_clk(4);

        // Preloaded reply A5, MOSI 3C, CS-fall latency of 3 clk.
        ur0 = underrun_cnt;
        offer(8'hA5);
        chk("t1_tx_ready_full", tx_ready, 1'b0);
        push_miso(8'hA5, 8);
        rx_exp_q.push_back(8'h3C);
        SPI_CS = 1'b0;
        wait_clk(2);
        chk("t1_oe_early", SPI_MISO_OE, 1'b0);
        wait_clk(1);
        chk("t1_oe_latency", SPI_MISO_OE, 1'b1);
        chk("t1_miso_first", SPI_MISO, 1'b1);
        chk("t1_selected", selected, 1'b1);
        chk("t1_tx_ready_freed", tx_ready, 1'b1);
        spi_send(32'h3C00_0000, 8, 1'b1);
        wait_clk(8);
        end_frame("t1", 0, ur0);

        // No reply: two bytes of fill, two underruns.
        ur0 = underrun_cnt;
        push_miso(8'hFF, 8);
        push_miso(8'hFF, 8);
        rx_exp_q.push_back(8'h9F);
        rx_exp_q.push_back(8'h00);
        spi_frame(32'h9F00_0000, 16);
        end_frame("t2", 2, ur0);

        // Streaming replies 11,22,33 from a concurrent producer.
        ur0 = underrun_cnt;
        r0  = rdy_rise_cnt;
        f0  = rdy_fall_cnt;
        push_miso(8'h11, 8);
        push_miso(8'h22, 8);
        push_miso(8'h33, 8);
        rx_exp_q.push_back(8'h01);
        rx_exp_q.push_back(8'h02);
        rx_exp_q.push_back(8'h03);
        offer(8'h11);
        fork
            spi_frame(32'h0102_0300, 24);
            begin
                offer(8'h22);
                offer(8'h33);
            end
        join
        end_frame("t3", 0, ur0);
        chk("t3_ready_falls", rdy_fall_cnt - f0, 32'd3);
        chk("t3_ready_rises", rdy_rise_cnt - r0, 32'd3);

        // Abort after 5 bits, then a clean 81.
        ur0 = underrun_cnt;
        push_miso(8'hFF, 5);
        SPI_CS = 1'b0;
        spi_send(32'hB000_0000, 5, 1'b1);
        wait_clk(8);
        end_frame("t4a", 1, ur0);
        ur0 = underrun_cnt;
        push_miso(8'hFF, 8);
        rx_exp_q.push_back(8'h81);
        spi_frame(32'h8100_0000, 8);
        end_frame("t4b", 1, ur0);

        // Reset mid-byte with a pending reply, then receive 5A.
        ur0 = underrun_cnt;
        push_miso(8'hFF, 3);
        SPI_CS = 1'b0;
        wait_clk(4);
        offer(8'hEE);
        chk("t5_tx_ready_full", tx_ready, 1'b0);
        spi_send(32'hA000_0000, 3, 1'b0);
        reset_n = 1'b0;
        wait_clk(1);
        SPI_CS = 1'b1;
        wait_clk(3);
        check_reset_vals("t5_reset");
        reset_n = 1'b1;
        wait_clk(4);
        push_miso(8'hFF, 8);
        rx_exp_q.push_back(8'h5A);
        spi_frame(32'h5A00_0000, 8);
        end_frame("t5", 2, ur0);

        // Header stream at SCK = clk/8.
        ur0 = underrun_cnt;
        push_miso(8'hFF, 8);
        push_miso(8'hFF, 8);
        push_miso(8'hFF, 8);
        push_miso(8'hFF, 8);
        rx_exp_q.push_back(8'h59);
        rx_exp_q.push_back(8'hA6);
        rx_exp_q.push_back(8'h00);
        rx_exp_q.push_back(8'h02);
        spi_frame(32'h59A6_0002, 32);
        end_frame("t6", 4, ur0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
